// File: rtl/dmem_ahb_responder.sv
// dmem_ahb_responder: AHB-lite single-transfer data-memory responder with programmable wait states
module dmem_ahb_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, acc_addr;
  logic wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d, wr_word, rd_word;
  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic accept, in_range, commit, unused_ok;
  assign unused_ok = ^{ms_riscv32_mp_dmaddr_in[1:0], ahb_htrans_in[0]};
  assign ahb_ready_out = state_q != S_WAIT && state_q != S_ERR1;
  assign ahb_resp_out = state_q == S_ERR1 || state_q == S_ERR2;
  assign ms_riscv32_mp_dmdata_out = rdata_q;
  assign accept = ahb_ready_out && ahb_htrans_in[1];
  assign acc_addr = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
  assign in_range = ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2] == '0;
  assign commit = state_q == S_LAST && wr_q && !ms_riscv32_mp_rst_in;
  always_comb begin
    wr_word = mem[addr_q];
    for (int i = 0; i < 4; i++)
      if (mask_q[i]) wr_word[8*i +: 8] = ms_riscv32_mp_dmdata_in[8*i +: 8];
  end
  // a read landing on the committing word must see the freshly merged lanes
  assign rd_word = (commit && addr_q == acc_addr) ? wr_word : mem[acc_addr];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    mask_d = mask_q;
    wr_d = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q <= 4'd1 ? S_LAST : S_WAIT;
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      addr_d = acc_addr;
      mask_d = ms_riscv32_mp_dmwr_mask_in;
      wr_d = ms_riscv32_mp_dmwr_req_in;
      state_d = !in_range ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_LAST);
      cnt_d = in_range ? 4'(WAIT_STATES) : 4'd0;
      rdata_d = ms_riscv32_mp_dmwr_req_in ? rdata_q : (in_range ? rd_word : 32'h0);
    end
  end
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      mask_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (commit) mem[addr_q] <= wr_word;
  end
endmodule

// File: tb/tb_dmem_ahb_responder.sv
// tb_dmem_ahb_responder: scoreboard bench driving one WAIT_STATES=1 and one WAIT_STATES=0 responder
module tb_dmem_ahb_responder;
  localparam int WS0 = 1;
  localparam int WS1 = 0;
  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          resp;
    int          waits;
  } exp_t;
  logic clk, rst;
  logic [31:0] addr [2], din [2], dout [2];
  logic [3:0]  mask [2];
  logic        wr [2], rdy [2], resp [2];
  logic [1:0]  htrans [2];
  exp_t q0 [$], q1 [$];
  int n_total = 0, n_pass = 0;

  dmem_ahb_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS0)) u0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(addr[0]), .ms_riscv32_mp_dmdata_in(din[0]),
    .ms_riscv32_mp_dmwr_mask_in(mask[0]), .ms_riscv32_mp_dmwr_req_in(wr[0]),
    .ahb_htrans_in(htrans[0]), .ms_riscv32_mp_dmdata_out(dout[0]),
    .ahb_ready_out(rdy[0]), .ahb_resp_out(resp[0]));
  dmem_ahb_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS1)) u1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(addr[1]), .ms_riscv32_mp_dmdata_in(din[1]),
    .ms_riscv32_mp_dmwr_mask_in(mask[1]), .ms_riscv32_mp_dmwr_req_in(wr[1]),
    .ahb_htrans_in(htrans[1]), .ms_riscv32_mp_dmdata_out(dout[1]),
    .ahb_ready_out(rdy[1]), .ahb_resp_out(resp[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
  endtask

  function automatic void push_exp(int id, exp_t e);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic bit pop_exp(int id, output exp_t e);
    if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
    if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
    e = '{0, 32'h0, 0, 0};
    return 1'b0;
  endfunction

  function automatic bit front_resp(int id);
    if (id == 0) return q0.size() > 0 ? q0[0].resp : 1'b0;
    return q1.size() > 0 ? q1[0].resp : 1'b0;
  endfunction

  task automatic mon(int id);
    bit act = 1'b0;
    int w = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
        w = 0;
      end else begin
        if (act && !rdy[id]) begin
          w++;
          chk($sformatf("u%0d wait_resp", id), {31'h0, resp[id]}, {31'h0, front_resp(id)});
        end else if (act) begin
          if (!pop_exp(id, e)) chk($sformatf("u%0d unexpected_phase", id), 32'h1, 32'h0);
          else begin
            chk($sformatf("u%0d resp", id), {31'h0, resp[id]}, {31'h0, e.resp});
            chk($sformatf("u%0d waits", id), 32'(w), 32'(e.waits));
            if (e.rd) chk($sformatf("u%0d rdata", id), dout[id], e.data);
          end
          w = 0;
        end
        if (rdy[id]) act = htrans[id][1];
      end
    end
  endtask

  initial fork mon(0); mon(1); join_none

  task automatic xfer(int id, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                      logic [31:0] ed, bit er, bit keep);
    int n = 0;
    exp_t e;
    htrans[id] = 2'b10;
    addr[id] = a;
    wr[id] = w;
    mask[id] = m;
    do begin @(negedge clk); n++; end while (!rdy[id] && n < 50);
    if (!rdy[id]) chk($sformatf("u%0d accept_timeout", id), 32'h0, 32'h1);
    @(posedge clk);
    #1;
    e.rd = !w;
    e.data = ed;
    e.resp = er;
    e.waits = er ? 1 : (id == 0 ? WS0 : WS1);
    if (keep) push_exp(id, e);
    htrans[id] = 2'b00;
    addr[id] = 32'hFFFF_FFFF;
    wr[id] = !w;
    mask[id] = ~m;
    if (w) din[id] = d;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d ready", tag, i), {31'h0, rdy[i]}, 32'h1);
      chk($sformatf("%s u%0d resp", tag, i), {31'h0, resp[i]}, 32'h0);
      chk($sformatf("%s u%0d dout", tag, i), dout[i], 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; din[i] = '0; mask[i] = '0; wr[i] = 1'b0; htrans[i] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");
    idle(2);
    // full word write then read
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1);
    idle(3);
    // byte-lane merges
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1);
    xfer(0, 1, 32'h20, 32'h000000AA, 4'h1, 32'h0, 0, 1);
    xfer(0, 1, 32'h20, 32'hBBBB0000, 4'hC, 32'h0, 0, 1);
    idle(1);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 32'hBBBB33AA, 0, 1);
    idle(3);
    // zero-wait bypass of a same-word read at the commit edge
    xfer(1, 1, 32'h40, 32'h00000000, 4'hF, 32'h0, 0, 1);
    xfer(1, 1, 32'h40, 32'hCAFEF00D, 4'h6, 32'h0, 0, 1);
    xfer(1, 0, 32'h40, 32'h0, 4'hF, 32'h00FEF000, 0, 1);
    idle(2);
    xfer(1, 0, 32'h40, 32'h0, 4'h0, 32'h00FEF000, 0, 1);
    xfer(1, 1, 32'h44, 32'h12345678, 4'h0, 32'h0, 0, 1);
    xfer(1, 0, 32'h80000010, 32'h0, 4'hF, 32'h0, 1, 1);
    idle(3);
    // out-of-range accesses, word 0 must stay intact
    xfer(0, 1, 32'h0, 32'h55AA55AA, 4'hF, 32'h0, 0, 1);
    xfer(0, 1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1, 1);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, 32'h55AA55AA, 0, 1);
    xfer(0, 0, 32'h80000010, 32'h0, 4'hF, 32'h0, 1, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1);
    idle(3);
    // reset in the wait state of a write aborts it
    xfer(0, 1, 32'h10, 32'h0BADF00D, 4'hF, 32'h0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("abort");
    idle(2);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1);
    xfer(1, 0, 32'h40, 32'h0, 4'hF, 32'h00FEF000, 0, 1);
    idle(4);
    chk("u0 drained", 32'(q0.size()), 32'h0);
    chk("u1 drained", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
